// File: rtl/td4_pkg.sv
// td4_pkg: opcode values, FSM states and ALU operand selects shared by the TD4 core.
package td4_pkg;
    localparam logic [3:0] OP_ADD_A = 4'b0000;
    localparam logic [3:0] OP_MOV_AB = 4'b0001;
    localparam logic [3:0] OP_IN_A = 4'b0010;
    localparam logic [3:0] OP_MOV_AI = 4'b0011;
    localparam logic [3:0] OP_MOV_BA = 4'b0100;
    localparam logic [3:0] OP_ADD_B = 4'b0101;
    localparam logic [3:0] OP_IN_B = 4'b0110;
    localparam logic [3:0] OP_MOV_BI = 4'b0111;
    localparam logic [3:0] OP_OUT_B = 4'b1001;
    localparam logic [3:0] OP_OUT_I = 4'b1011;
    localparam logic [3:0] OP_JNC = 4'b1110;
    localparam logic [3:0] OP_JMP = 4'b1111;
    typedef enum logic {ST_FETCH, ST_EXEC} state_t;
    typedef enum logic [1:0] {SRC_A, SRC_B, SRC_IN, SRC_ZERO} src_t;
endpackage

// File: rtl/td4_alu.sv
// td4_alu: selects one of {A, B, in_port, 0} and adds the immediate (or 0) with carry-out.
module td4_alu
    import td4_pkg::*;
#(
    parameter int DATA_W = 4
) (
    input  src_t              src,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [DATA_W-1:0] in_port,
    input  logic [DATA_W-1:0] imm,
    input  logic              use_imm,
    output logic [DATA_W-1:0] sum,
    output logic              cout
);
    logic [DATA_W-1:0] opnd, addend;
    always_comb begin
        opnd = src == SRC_A ? a : src == SRC_B ? b : src == SRC_IN ? in_port : '0;
        addend = use_imm ? imm : '0;
    end
    assign {cout, sum} = {1'b0, opnd} + {1'b0, addend};
endmodule

// File: rtl/td4_core_param.sv
// td4_core_param: 2-cycle FETCH/EXEC accumulator core running the TD4 instruction set
// from an external synchronous ROM, with carry-conditional jumps and run/halt control.
module td4_core_param
    import td4_pkg::*;
#(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 4,
    localparam int INSTR_W = 4 + DATA_W
) (
    input  logic               clk0,
    input  logic               rst,
    input  logic               run,
    output logic [ADDR_W-1:0]  rom_addr,
    output logic               rom_rd,
    input  logic [INSTR_W-1:0] rom_data,
    input  logic [DATA_W-1:0]  in_port,
    output logic [DATA_W-1:0]  out_port,
    output logic               carry,
    output logic [ADDR_W-1:0]  pc,
    output logic               retire
);
    state_t st, st_nx;
    src_t src;
    logic [DATA_W-1:0] a, b, res, imm;
    logic [3:0] op;
    logic use_imm, wr_a, wr_b, wr_o, is_add, jmp, cout;
    assign op = rom_data[INSTR_W-1 -: 4];
    assign imm = rom_data[DATA_W-1:0];
    assign rom_addr = pc;
    assign rom_rd = !rst && st == ST_FETCH && run;
    always_comb begin
        st_nx = (st == ST_FETCH && run) ? ST_EXEC : ST_FETCH;
        src = SRC_ZERO;
        use_imm = 1'b1;
        wr_a = 1'b0;
        wr_b = 1'b0;
        wr_o = 1'b0;
        is_add = 1'b0;
        jmp = 1'b0;
        case (op)
            OP_ADD_A: begin src = SRC_A; wr_a = 1'b1; is_add = 1'b1; end
            OP_ADD_B: begin src = SRC_B; wr_b = 1'b1; is_add = 1'b1; end
            OP_MOV_AI: wr_a = 1'b1;
            OP_MOV_BI: wr_b = 1'b1;
            OP_MOV_AB: begin src = SRC_B; use_imm = 1'b0; wr_a = 1'b1; end
            OP_MOV_BA: begin src = SRC_A; use_imm = 1'b0; wr_b = 1'b1; end
            OP_IN_A: begin src = SRC_IN; use_imm = 1'b0; wr_a = 1'b1; end
            OP_IN_B: begin src = SRC_IN; use_imm = 1'b0; wr_b = 1'b1; end
            OP_OUT_B: begin src = SRC_B; use_imm = 1'b0; wr_o = 1'b1; end
            OP_OUT_I: wr_o = 1'b1;
            OP_JMP: jmp = 1'b1;
            OP_JNC: jmp = !carry;
            default: ;
        endcase
    end
    td4_alu #(.DATA_W(DATA_W)) u_alu (
        .src(src), .a(a), .b(b), .in_port(in_port), .imm(imm),
        .use_imm(use_imm), .sum(res), .cout(cout)
    );
    // Carry is read by JNC before being overwritten here, so the condition sees the old flag.
    always_ff @(posedge clk0 or posedge rst) begin
        if (rst) begin
            st <= ST_FETCH;
            a <= '0;
            b <= '0;
            out_port <= '0;
            carry <= 1'b0;
            pc <= '0;
            retire <= 1'b0;
        end else begin
            st <= st_nx;
            retire <= st == ST_EXEC;
            if (st == ST_EXEC) begin
                if (wr_a) a <= res;
                if (wr_b) b <= res;
                if (wr_o) out_port <= res;
                carry <= is_add & cout;
                pc <= jmp ? imm[ADDR_W-1:0] : pc + ADDR_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_td4_core_param.sv
// tb_td4_core_param: randomized and directed programs scored against an instruction-level model.
module tb_td4_core_param;
    logic clk0 = 1'b0, rst = 1'b1, run = 1'b0;
    logic [3:0] rom_addr, in_port = '0, out_port, pc;
    logic rom_rd, carry, retire;
    logic [7:0] rom_data = '0;
    logic [7:0] rom [16];

    logic rst8 = 1'b1, run8 = 1'b0;
    logic [5:0] rom_addr8, pc8;
    logic [7:0] in8 = '0, out8;
    logic rom_rd8, carry8, retire8;
    logic [11:0] rom_data8 = '0;
    logic [11:0] rom8 [64];

    typedef struct {int pc; int c; int o;} exp_t;
    exp_t q[$];
    int total = 0, bad = 0;
    int ma, mb, mo, mc, mpc, m_in;

    td4_core_param #(.DATA_W(4), .ADDR_W(4)) dut (
        .clk0(clk0), .rst(rst), .run(run), .rom_addr(rom_addr), .rom_rd(rom_rd),
        .rom_data(rom_data), .in_port(in_port), .out_port(out_port), .carry(carry),
        .pc(pc), .retire(retire)
    );
    td4_core_param #(.DATA_W(8), .ADDR_W(6)) dut8 (
        .clk0(clk0), .rst(rst8), .run(run8), .rom_addr(rom_addr8), .rom_rd(rom_rd8),
        .rom_data(rom_data8), .in_port(in8), .out_port(out8), .carry(carry8),
        .pc(pc8), .retire(retire8)
    );

    always #5 clk0 = ~clk0;

    // Synchronous ROMs; junk is presented whenever no read was strobed.
    always @(posedge clk0) begin
        rom_data <= rom_rd ? rom[rom_addr] : 8'($urandom);
        rom_data8 <= rom_rd8 ? rom8[rom_addr8] : 12'($urandom);
    end

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Architectural model: one call executes the instruction at mpc.
    task automatic model_step();
        int ins, op, i, nc, j;
        ins = int'(rom[mpc]);
        op = ins / 16;
        i = ins % 16;
        nc = 0;
        j = 0;
        case (op)
            0: begin nc = (ma + i) / 16; ma = (ma + i) % 16; end
            5: begin nc = (mb + i) / 16; mb = (mb + i) % 16; end
            3: ma = i;
            7: mb = i;
            1: ma = mb;
            4: mb = ma;
            2: ma = m_in;
            6: mb = m_in;
            9: mo = mb;
            11: mo = i;
            15: j = 1;
            14: j = (mc == 0) ? 1 : 0;
            default: ;
        endcase
        mc = nc;
        mpc = (j != 0) ? i : (mpc + 1) % 16;
        q.push_back('{mpc, mc, mo});
    endtask

    always @(negedge clk0) begin
        exp_t e;
        if (retire) begin
            check("sb_expected", int'(q.size() > 0), 1);
            if (q.size() > 0) begin
                e = q.pop_front();
                check("sb_pc", int'(pc), e.pc);
                check("sb_carry", int'(carry), e.c);
                check("sb_out", int'(out_port), e.o);
            end
        end
    end

    // Resets the core, runs exactly n instructions and lets the monitor score them.
    task automatic segment(input int n, input int in_val, input bit rnd_run,
                           input int pause_at, output int nret, output int last);
        int fetched = 0, hold = 0, cyc = 0, guard = 0;
        bit ex = 0, held = 0;
        nret = 0;
        last = 0;
        rst = 1'b1;
        run = 1'b0;
        in_port = 4'(in_val);
        m_in = in_val;
        ma = 0; mb = 0; mo = 0; mc = 0; mpc = 0;
        repeat (2) @(negedge clk0);
        for (int k = 0; k < n; k++) model_step();
        rst = 1'b0;
        while (guard < 8 * n + 40 && (fetched < n || q.size() > 0)) begin
            if (ex) ex = 0;
            else begin
                if (held) begin
                    check("halt_rd", int'(rom_rd), 0);
                    check("halt_pc", int'(pc), pause_at);
                end
                held = hold > 0;
                if (hold > 0) begin
                    run = 1'b0;
                    hold--;
                end else run = fetched < n && (!rnd_run || $urandom_range(3) != 0);
                if (run) begin
                    fetched++;
                    ex = 1;
                    if (fetched == pause_at) hold = 6;
                end
            end
            @(negedge clk0);
            cyc++;
            guard++;
            if (retire) begin
                nret++;
                last = cyc;
            end
        end
        run = 1'b0;
        check("drain", q.size(), 0);
        repeat (4) @(negedge clk0);
    endtask

    initial begin
        int nret, last, w;
        int e_pc8 [5] = '{1, 2, 3, 4, 63};
        int e_c8 [5] = '{0, 1, 0, 0, 0};
        int e_o8 [5] = '{0, 0, 0, 16, 16};
        for (int k = 0; k < 16; k++) rom[k] = 8'h80;
        rom[0] = 8'h35;
        repeat (2) @(negedge clk0);
        check("rst_pc", int'(pc), 0);
        check("rst_carry", int'(carry), 0);
        check("rst_out", int'(out_port), 0);
        check("rst_rd", int'(rom_rd), 0);
        check("rst_retire", int'(retire), 0);
        // Release, fetch MOV A,5, then reset again in the middle of its EXEC cycle.
        rst = 1'b0;
        run = 1'b1;
        #1;
        check("first_rd", int'(rom_rd), 1);
        check("first_addr", int'(rom_addr), 0);
        @(posedge clk0);
        #2 rst = 1'b1;
        @(negedge clk0);
        check("exec_rst_retire", int'(retire), 0);
        check("exec_rst_pc", int'(pc), 0);
        @(posedge clk0);
        #1 check("exec_rst_retire2", int'(retire), 0);
        run = 1'b0;

        rom[0] = 8'h33; rom[1] = 8'h0E; rom[2] = 8'hE0; rom[3] = 8'hE0;
        segment(4, 0, 0, 0, nret, last);
        check("carry_retires", nret, 4);

        rom[0] = 8'h20; rom[1] = 8'h40; rom[2] = 8'h90; rom[3] = 8'hBA;
        segment(4, 5, 0, 0, nret, last);

        for (int k = 0; k < 16; k++) rom[k] = 8'h80;
        segment(16, 0, 0, 0, nret, last);
        check("nop_retires", nret, 16);
        check("nop_cycles", last, 32);

        segment(6, 0, 0, 3, nret, last);
        check("pause_retires", nret, 6);

        for (int s = 0; s < 10; s++) begin
            for (int k = 0; k < 16; k++) rom[k] = 8'($urandom);
            segment(30, int'($urandom_range(15)), 1, 0, nret, last);
            check("rand_retires", nret, 30);
        end

        for (int k = 0; k < 64; k++) rom8[k] = 12'h800;
        rom8[0] = 12'h3F0; rom8[1] = 12'h020; rom8[2] = 12'h400;
        rom8[3] = 12'h900; rom8[4] = 12'hFFF;
        @(negedge clk0);
        rst8 = 1'b0;
        run8 = 1'b1;
        for (int k = 0; k < 5; k++) begin
            w = 0;
            do begin
                @(negedge clk0);
                w++;
            end while (!retire8 && w < 10);
            check("w8_retire", int'(retire8), 1);
            check("w8_pc", int'(pc8), e_pc8[k]);
            check("w8_carry", int'(carry8), e_c8[k]);
            check("w8_out", int'(out8), e_o8[k]);
        end
        run8 = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
